// File: rtl/ncpu32k_dbus_arb.sv
// ---------------------------------------------------------------------------
// ncpu32k_dbus_arb
//
// Shares one data-bus slave between two requesters: requester 0 (memory
// unit) and requester 1 (debug / DMA style master).
//
// Command channel: round-robin grant. The grant is held (locked) on a
// requester whose command is presented but not yet accepted. Each accepted
// command's owner is pushed into an in-order owner FIFO of OUTSTANDING
// entries. New commands are withheld while the FIFO is full.
//
// Response channel: the owner at the FIFO head receives dbus_valid. Its
// ready is reflected back to the slave. A response handshake pops the FIFO.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   m{0,1}_cmd_valid / _cmd_ready       requester command handshake
//   m{0,1}_cmd_addr / _cmd_we_msk / _din  command payload (mask 0 = load)
//   m{0,1}_valid / _ready / _dout       response to requester
//   dbus_cmd_valid / _cmd_ready         command handshake to slave
//   dbus_cmd_addr / _cmd_we_msk / dbus_din  muxed command payload
//   dbus_valid / dbus_ready / dbus_dout slave response handshake and data
// ---------------------------------------------------------------------------
module ncpu32k_dbus_arb #(
    parameter int OUTSTANDING = 2,
    parameter int NCPU_AW     = 32,
    parameter int NCPU_DW     = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   m0_cmd_valid,
    output logic                   m0_cmd_ready,
    input  logic [NCPU_AW-1:0]     m0_cmd_addr,
    input  logic [NCPU_DW/8-1:0]   m0_cmd_we_msk,
    input  logic [NCPU_DW-1:0]     m0_din,
    output logic                   m0_valid,
    input  logic                   m0_ready,
    output logic [NCPU_DW-1:0]     m0_dout,

    input  logic                   m1_cmd_valid,
    output logic                   m1_cmd_ready,
    input  logic [NCPU_AW-1:0]     m1_cmd_addr,
    input  logic [NCPU_DW/8-1:0]   m1_cmd_we_msk,
    input  logic [NCPU_DW-1:0]     m1_din,
    output logic                   m1_valid,
    input  logic                   m1_ready,
    output logic [NCPU_DW-1:0]     m1_dout,

    output logic                   dbus_cmd_valid,
    input  logic                   dbus_cmd_ready,
    output logic [NCPU_AW-1:0]     dbus_cmd_addr,
    output logic [NCPU_DW/8-1:0]   dbus_cmd_we_msk,
    output logic [NCPU_DW-1:0]     dbus_din,
    input  logic                   dbus_valid,
    output logic                   dbus_ready,
    input  logic [NCPU_DW-1:0]     dbus_dout
);

    // A one-entry FIFO still needs a 1-bit pointer; it simply stays at 0.
    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUTSTANDING - 1);

    // State
    logic                   r_last_gnt;
    logic                   r_lock;
    logic                   r_lock_id;
    logic [OUTSTANDING-1:0] r_fifo;
    logic [PTR_W-1:0]       r_wptr;
    logic [PTR_W-1:0]       r_rptr;
    logic [CNT_W-1:0]       r_cnt;

    // Combinational
    logic [1:0]             w_cmd_valid;
    logic [1:0]             w_cmd_ready;
    logic [1:0]             w_rsp_ready;
    logic [1:0]             w_rsp_valid;
    logic                   w_gnt;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_head;
    logic                   w_push;
    logic                   w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_cmd_valid = {m1_cmd_valid, m0_cmd_valid};
    assign w_rsp_ready = {m1_ready, m0_ready};

    assign w_full  = (r_cnt == CNT_FULL);
    assign w_empty = (r_cnt == '0);
    assign w_head  = r_fifo[r_rptr];

    // Grant: a locked requester keeps the bus until its command is taken.
    // With no lock, a lone requester wins; on contention (or idle) the one
    // that did not win last time is selected.
    always_comb begin
        w_gnt = ~r_last_gnt;
        if (r_lock) begin
            w_gnt = r_lock_id;
        end else if (w_cmd_valid == 2'b01) begin
            w_gnt = 1'b0;
        end else if (w_cmd_valid == 2'b10) begin
            w_gnt = 1'b1;
        end
    end

    // Command channel mux
    assign dbus_cmd_valid  = w_cmd_valid[w_gnt] & ~w_full;
    assign dbus_cmd_addr   = w_gnt ? m1_cmd_addr   : m0_cmd_addr;
    assign dbus_cmd_we_msk = w_gnt ? m1_cmd_we_msk : m0_cmd_we_msk;
    assign dbus_din        = w_gnt ? m1_din        : m0_din;

    // Response channel: only the recorded owner sees valid; the slave sees
    // that owner's ready. Nothing is accepted while no command is in flight.
    assign dbus_ready = ~w_empty & w_rsp_ready[w_head];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign w_cmd_ready[gi] = (w_gnt == 1'(gi)) & dbus_cmd_ready & ~w_full;
            assign w_rsp_valid[gi] = dbus_valid & ~w_empty & (w_head == 1'(gi));
        end
    endgenerate

    assign m0_cmd_ready = w_cmd_ready[0];
    assign m1_cmd_ready = w_cmd_ready[1];
    assign m0_valid     = w_rsp_valid[0];
    assign m1_valid     = w_rsp_valid[1];
    assign m0_dout      = dbus_dout;
    assign m1_dout      = dbus_dout;

    assign w_push = dbus_cmd_valid & dbus_cmd_ready;
    assign w_pop  = dbus_valid & dbus_ready;

    // Grant history and lock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_gnt <= 1'b1;
            r_lock     <= 1'b0;
            r_lock_id  <= 1'b0;
        end else begin
            if (w_push) begin
                r_last_gnt <= w_gnt;
                r_lock     <= 1'b0;
            end else if (dbus_cmd_valid) begin
                r_lock     <= 1'b1;
                r_lock_id  <= w_gnt;
            end
        end
    end

    // Owner FIFO and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wptr] <= w_gnt;
                r_wptr         <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

`ifdef NCPU_ENABLE_ASSERT
    // A response with nothing outstanding means the slave broke protocol.
    always_ff @(posedge clk) begin
        if (rst_n && dbus_valid && w_empty) begin
            $fatal(1, "ncpu32k_dbus_arb: dbus_valid with no outstanding command");
        end
    end
`endif

endmodule

// File: doc/ncpu32k_dbus_arb.md
# ncpu32k_dbus_arb

Two-requester arbiter sharing the single data bus (dbus) between the memory unit (requester 0) and a second master such as a debug or DMA port (requester 1). Grants the command channel round-robin, holds the grant stable while a command is unaccepted, and records the owner of each outstanding command in an in-order FIFO. Returning read data is routed to the recorded owner, so a requester never sees responses issued to the other. Sits between the MU/second master and the dbus slave (cache/MMU side).

## Interface
- `OUTSTANDING`, 2, maximum commands in flight; power of 2, range 1..8.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `m0_cmd_valid` / `m1_cmd_valid`  in  1  requester command valid.
- `m0_cmd_ready` / `m1_cmd_ready`  out  1  command accepted for that requester.
- `m0_cmd_addr` / `m1_cmd_addr`  in  `NCPU_AW`  command address.
- `m0_cmd_we_msk` / `m1_cmd_we_msk`  in  `NCPU_DW/8`  byte write mask; 0 means load.
- `m0_din` / `m1_din`  in  `NCPU_DW`  store data.
- `m0_valid` / `m1_valid`  out  1  response data valid to that requester.
- `m0_ready` / `m1_ready`  in  1  requester accepts response.
- `m0_dout` / `m1_dout`  out  `NCPU_DW`  response data; both equal `dbus_dout`.
- `dbus_cmd_valid`  out  1  command to slave.
- `dbus_cmd_ready`  in  1  slave accepts command.
- `dbus_cmd_addr`  out  `NCPU_AW`  muxed address.
- `dbus_cmd_we_msk`  out  `NCPU_DW/8`  muxed write mask.
- `dbus_din`  out  `NCPU_DW`  muxed store data.
- `dbus_valid`  in  1  slave response valid.
- `dbus_ready`  out  1  arbiter accepts response.
- `dbus_dout`  in  `NCPU_DW`  slave response data.

## Operation
- State: `last_gnt_r` (1 bit), `lock_r` + `lock_id_r`, owner FIFO (`OUTSTANDING` x 1 bit, write/read pointers), occupancy counter `cnt_r` (0..`OUTSTANDING`).
- `full = (cnt_r == OUTSTANDING)`; `empty = (cnt_r == 0)`.
- Grant selection: if `lock_r`, `gnt = lock_id_r`. Otherwise, if only one requester is valid, grant it. If both are valid, grant `~last_gnt_r`. If neither is valid, `gnt = ~last_gnt_r`, with no effect.
- `dbus_cmd_valid = m[gnt]_cmd_valid & ~full`. Address, mask and data are muxed by `gnt`.
- `m[i]_cmd_ready = (gnt==i) & dbus_cmd_ready & ~full`. The non-granted ready is 0.
- Lock: set with `lock_id_r <= gnt` when `dbus_cmd_valid & ~dbus_cmd_ready`. Cleared on the command handshake. A requester holding valid keeps the grant even if the other requester asserts.
- Command handshake (`dbus_cmd_valid & dbus_cmd_ready`): push `gnt` into the FIFO and set `last_gnt_r <= gnt`.
- Response routing: `head` = FIFO read entry. `m[i]_valid = dbus_valid & ~empty & (head==i)`. `dbus_ready = ~empty & m[head]_ready`. A response handshake pops the FIFO.
- Counter: push only gives +1; pop only gives −1; push and pop in the same cycle leave it unchanged, with both pointers advancing. Pointers wrap modulo `OUTSTANDING`.
- Full: no new command is issued, but responses still drain. The cycle after a pop from full, a command may issue.
- Empty: `dbus_ready = 0`. A `dbus_valid` while empty is a slave protocol error and triggers `$fatal` under `NCPU_ENABLE_ASSERT`. The slave must not respond in the same cycle its command is accepted while the FIFO is empty.

## Timing
- Reset values: `cnt_r = 0`, pointers 0, `lock_r = 0`, `last_gnt_r = 1` (so requester 0 wins the first contention).
- Output values under reset:
  - `dbus_cmd_valid` follows the requester valids.
  - `dbus_ready = 0`.
  - `m0_valid = m1_valid = 0`.
  - `m*_cmd_ready` follows `dbus_cmd_ready`.
- Latency: zero added cycles on both channels; all muxes and readies are combinational from inputs and state.
- Throughput: one command per cycle while not full; one response per cycle.
- Reset mid-operation clears the FIFO and lock. Outstanding responses are lost, and the slave must be reset together with the arbiter.

## Test plan
- **Single requester.** After reset, m0 issues a load to `addr=0x100`; the slave accepts, then returns `0xDEADBEEF` 2 cycles later. Required:
  - `m0_cmd_ready` pulses once.
  - `m0_valid` is high with `m0_dout=0xDEADBEEF`.
  - `m1_valid` stays 0.
  - `cnt_r` goes 0→1→0.
- **Contention round-robin.** m0 and m1 are both valid every cycle with `dbus_cmd_ready=1`. Required: grants go m0, m1, m0, m1, and the FIFO holds {0,1}.
- **Lock.** m1 is valid alone with `dbus_cmd_ready=0` for 3 cycles, and m0 asserts on cycle 2. Required:
  - `dbus_cmd_addr` stays m1's address.
  - `m0_cmd_ready` stays 0.
  - m1 is accepted when ready rises; m0 is granted next.
- **Full stall.** With `OUTSTANDING=2`, issue 2 commands and withhold responses. Required:
  - The third command is held with `dbus_cmd_valid=0`.
  - After the first response handshake, the third command issues the next cycle.
- **Ordered routing with backpressure.** Outstanding owners are {1,0}. The response comes with `m1_ready=0` for 2 cycles. Required:
  - `dbus_ready=0` and `m0_valid=0` during that time.
  - After `m1_ready` rises, the next response goes to m0.
- **Simultaneous push/pop.** At `cnt_r=1`, a command handshake and a response handshake occur in the same cycle. Required: `cnt_r` stays 1 and the pointers each advance by 1.
